issue_queue: RTL and testbench
==============================

Name: issue_queue

Overview:
- Unified issue queue that terminates the decode/dispatch-to-issue interface.
- Each cycle it accepts at most one renamed micro-op from the decode stage's pipeline register (DC_valid / IS_ready handshake).
- It holds up to IQ_LEN entries and tracks operand readiness through busy-table lookup at insert plus writeback tag wakeup.
- Each cycle it selects the oldest fully-ready entry whose functional unit is free and sends it to register read / execute.

Parameters:
- IQ_LEN, 8, number of entries (power of 2, ≥2).
- ROB_LEN, 16, ROB depth; rob_idx width = clog2(ROB_LEN).
- PREG_W, 7, physical register tag width.
- WB_PORTS, 2, number of wakeup broadcast ports.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- DC_valid  in  1  decode-stage payload valid (already qualified with IS_ready)
- DC_out_imm  in  32  immediate
- DC_out_op  in  5  opcode[6:2]
- DC_out_f3  in  3  funct3
- DC_out_f7  in  7  funct7
- DC_out_P_rs1  in  PREG_W  source 1 tag
- DC_out_P_rs2  in  PREG_W  source 2 tag
- DC_out_P_rd  in  PREG_W  destination tag
- DC_out_fu_sel  in  3  FU class 0..7
- DC_out_rob_idx  in  clog2(ROB_LEN)  ROB slot
- DC_out_jump  in  1  predicted-taken flag
- DC_out_pc  in  32  pc
- rs1_busy  in  1  busy-table bit for DC_out_P_rs1, sampled this cycle
- rs2_busy  in  1  busy-table bit for DC_out_P_rs2, sampled this cycle
- IS_ready  out  1  a free entry exists
- wb_valid  in  WB_PORTS  wakeup valid per port
- wb_tag  in  WB_PORTS*PREG_W  wakeup tags
- rob_head  in  clog2(ROB_LEN)  oldest in-flight ROB index
- fu_ready  in  8  per-FU-class accept
- iss_valid  out  1  an issuable entry is selected
- iss_pc, iss_imm, iss_op, iss_f3, iss_f7, iss_P_rs1, iss_P_rs2, iss_P_rd, iss_fu_sel, iss_rob_idx, iss_jump  out  (widths as inputs)  selected payload
- mispredict  in  1  flush all entries
- iq_count  out  clog2(IQ_LEN)+1  occupancy (debug/perf)

Behaviour:
- Storage: per entry a valid bit, the payload, rdy1, and rdy2.
- Reset: all valid bits cleared; iq_count=0; IS_ready=1; iss_valid=0. Payload contents are don't-care.
- IS_ready = (iq_count < IQ_LEN), derived from registered state only. A same-cycle issue does not raise it. This prevents a combinational loop through DC_valid.
- Insert (DC_valid && IS_ready && !mispredict):
  - The lowest-numbered free entry is written at the clock edge.
  - rdy1 = !rs1_busy || P_rs1==0 || (P_rs1 matches any valid wb_tag this cycle). rdy2 is the same rule for rs2.
- Wakeup: for every valid entry, a valid wb_tag[k] that equals the entry's source tag (tag≠0) sets that rdy bit at the next edge. Multiple simultaneous matches are harmless.
- Select (combinational):
  - Candidates are entries with valid && rdy1 && rdy2 && fu_ready[fu_sel].
  - Age = (rob_idx − rob_head) mod ROB_LEN. The smallest age wins; ties (impossible in legal operation) go to the lowest entry index.
  - iss_valid = any candidate exists; iss_* = winner's payload.
  - When iss_valid is set, the winner is cleared at the next edge; issue is accepted unconditionally because fu_ready is already folded in.
- An entry written this cycle is not visible to select until the next cycle. Minimum insert-to-issue latency is 1 cycle.
- Count update: iq_count += insert − issue. Simultaneous insert and issue leaves the count unchanged.
- mispredict: all valid bits are cleared at the edge, iq_count=0, and insert is suppressed that cycle. iss_valid is still driven combinationally in the mispredict cycle; the downstream stage discards it on mispredict.
- rst mid-operation: same effect as mispredict, plus any wakeups are dropped.
- Full case: with IQ_LEN entries valid, IS_ready=0. A DC_valid in that cycle cannot occur, because it is qualified by IS_ready.

Decomposition:
- Shared package holds:
  - opcode constants (R_TYPE, F_TYPE, LOAD, etc.);
  - FU-class encodings (ALU=0, MUL=1, DIV=2, FALU=3, FMUL=4, FDIV=5, LSU=6, CSR=7);
  - the iq_entry_t packed struct.
- One sub-module, iq_age_select: combinational oldest-ready picker. Inputs are the request vector, rob_idx array, and rob_head; outputs are a one-hot grant and a valid.

Test Plan:
- Reset, then insert 8 micro-ops with rs busy=0 and fu_ready=0 → IS_ready falls after the 8th insert; iq_count=8; iss_valid=0.
- Insert ADD (P_rs1=12 busy) at rob_idx 3; pulse wb_tag=12 two cycles later → iss_valid in the cycle after the wakeup, iss_rob_idx=3.
- Insert at rob_idx 14, 15, 0, 1 with rob_head=14, all ready, fu_ready=all ones → issue order 14, 15, 0, 1 (wrap-around age).
- Insert with rs1_busy=1 while wb_tag equals P_rs1 in the same cycle → rdy1 set at insert, issue next cycle.
- Ready MUL (fu_sel=1) with fu_ready[1]=0 and a younger ready ALU entry → ALU issues first; MUL issues once fu_ready[1]=1.
- Fill with 5 entries, assert mispredict together with DC_valid → next cycle iq_count=0, iss_valid=0, IS_ready=1, new entry not inserted.

Source files
------------

// File: rtl/issue_queue_pkg.sv
// Shared definitions for the issue queue: opcode constants, functional-unit
// classes, the per-entry storage layout and the ROB age helper.
package issue_queue_pkg;

    // Machine-wide widths that shape the stored payload.
    localparam int PREG_W  = 7;
    localparam int ROB_LEN = 16;
    localparam int ROB_W   = $clog2(ROB_LEN);

    // Major opcodes, instruction bits [6:2].
    localparam logic [4:0] OP_LOAD     = 5'b00000;
    localparam logic [4:0] OP_LOAD_FP  = 5'b00001;
    localparam logic [4:0] OP_MISC_MEM = 5'b00011;
    localparam logic [4:0] OP_I_TYPE   = 5'b00100;
    localparam logic [4:0] OP_AUIPC    = 5'b00101;
    localparam logic [4:0] OP_STORE    = 5'b01000;
    localparam logic [4:0] OP_STORE_FP = 5'b01001;
    localparam logic [4:0] OP_R_TYPE   = 5'b01100;
    localparam logic [4:0] OP_LUI      = 5'b01101;
    localparam logic [4:0] OP_FMADD    = 5'b10000;
    localparam logic [4:0] OP_F_TYPE   = 5'b10100;
    localparam logic [4:0] OP_BRANCH   = 5'b11000;
    localparam logic [4:0] OP_JALR     = 5'b11001;
    localparam logic [4:0] OP_JAL      = 5'b11011;
    localparam logic [4:0] OP_SYSTEM   = 5'b11100;

    // Functional-unit classes; the value indexes fu_ready.
    typedef enum logic [2:0] {
        FU_ALU  = 3'd0,
        FU_MUL  = 3'd1,
        FU_DIV  = 3'd2,
        FU_FALU = 3'd3,
        FU_FMUL = 3'd4,
        FU_FDIV = 3'd5,
        FU_LSU  = 3'd6,
        FU_CSR  = 3'd7
    } fu_class_e;

    // Micro-op payload carried from dispatch to issue unchanged.
    typedef struct packed {
        logic [31:0]       pc;
        logic [31:0]       imm;
        logic [4:0]        op;
        logic [2:0]        f3;
        logic [6:0]        f7;
        logic [PREG_W-1:0] p_rs1;
        logic [PREG_W-1:0] p_rs2;
        logic [PREG_W-1:0] p_rd;
        logic [2:0]        fu_sel;
        logic [ROB_W-1:0]  rob_idx;
        logic              jump;
    } iq_payload_t;

    // One queue slot: occupancy, operand readiness and payload.
    typedef struct packed {
        logic        valid;
        logic        rdy1;
        logic        rdy2;
        iq_payload_t pl;
    } iq_entry_t;

    // Distance from the ROB head; smaller means older. Wraps naturally.
    function automatic logic [ROB_W-1:0] rob_age(input logic [ROB_W-1:0] idx,
                                                 input logic [ROB_W-1:0] head);
        return idx - head;
    endfunction

endpackage

// File: rtl/iq_age_select.sv
// Combinational oldest-first picker: among requesting slots, grants the one
// whose ROB index is closest to the ROB head; ties go to the lowest slot.
module iq_age_select
    import issue_queue_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]            req,
    input  logic [N-1:0][ROB_W-1:0] rob_idx,
    input  logic [ROB_W-1:0]        rob_head,
    output logic [N-1:0]            grant,
    output logic                    valid
);

    localparam int SEL_W = $clog2(N);

    logic [ROB_W-1:0] best_age;
    logic [SEL_W-1:0] best_idx;

    // Linear scan keeping the smallest age; strict compare keeps the lower slot on ties.
    always_comb begin
        grant    = '0;
        valid    = 1'b0;
        best_age = '0;
        best_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && (!valid || (rob_age(rob_idx[i], rob_head) < best_age))) begin
                valid    = 1'b1;
                best_age = rob_age(rob_idx[i], rob_head);
                best_idx = SEL_W'(i);
            end
        end
        if (valid) begin
            grant[best_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/issue_queue.sv
// Unified issue queue between dispatch and register read. Holds renamed
// micro-ops, wakes operands from writeback tag broadcasts and issues the
// oldest fully-ready micro-op whose functional unit can accept it.
//
// Handshake: dispatch presents DC_valid only when IS_ready was high in that
// same cycle, and a micro-op is taken on the edge where DC_valid && IS_ready
// && !mispredict. IS_ready comes from registered occupancy alone, so it never
// depends on DC_valid or on a same-cycle issue. Issue has no back-pressure:
// iss_valid already includes fu_ready, so the winner leaves on the next edge.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int IQ_LEN   = 8,
    parameter int WB_PORTS = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         DC_valid,
    input  logic [31:0]                  DC_out_imm,
    input  logic [4:0]                   DC_out_op,
    input  logic [2:0]                   DC_out_f3,
    input  logic [6:0]                   DC_out_f7,
    input  logic [PREG_W-1:0]            DC_out_P_rs1,
    input  logic [PREG_W-1:0]            DC_out_P_rs2,
    input  logic [PREG_W-1:0]            DC_out_P_rd,
    input  logic [2:0]                   DC_out_fu_sel,
    input  logic [ROB_W-1:0]             DC_out_rob_idx,
    input  logic                         DC_out_jump,
    input  logic [31:0]                  DC_out_pc,
    input  logic                         rs1_busy,
    input  logic                         rs2_busy,
    output logic                         IS_ready,
    input  logic [WB_PORTS-1:0]          wb_valid,
    input  logic [WB_PORTS*PREG_W-1:0]   wb_tag,
    input  logic [ROB_W-1:0]             rob_head,
    input  logic [7:0]                   fu_ready,
    output logic                         iss_valid,
    output logic [31:0]                  iss_pc,
    output logic [31:0]                  iss_imm,
    output logic [4:0]                   iss_op,
    output logic [2:0]                   iss_f3,
    output logic [6:0]                   iss_f7,
    output logic [PREG_W-1:0]            iss_P_rs1,
    output logic [PREG_W-1:0]            iss_P_rs2,
    output logic [PREG_W-1:0]            iss_P_rd,
    output logic [2:0]                   iss_fu_sel,
    output logic [ROB_W-1:0]             iss_rob_idx,
    output logic                         iss_jump,
    input  logic                         mispredict,
    output logic [$clog2(IQ_LEN):0]      iq_count
);

    localparam int IDX_W = $clog2(IQ_LEN);
    localparam int CNT_W = IDX_W + 1;

    iq_entry_t                     q [IQ_LEN];
    logic [CNT_W-1:0]              count_q;

    logic                          insert;
    logic                          issue;
    logic [IDX_W-1:0]              free_idx;
    iq_payload_t                   ins_pl;
    logic                          ins_rdy1;
    logic                          ins_rdy2;

    logic [IQ_LEN-1:0]             req;
    logic [IQ_LEN-1:0]             grant;
    logic [IQ_LEN-1:0][ROB_W-1:0]  rob_vec;
    iq_payload_t                   sel_pl;

    // True when a valid broadcast carries this tag; tag 0 is the hardwired
    // zero register and never needs waking.
    function automatic logic tag_hit(input logic [PREG_W-1:0]          tag,
                                     input logic [WB_PORTS-1:0]        v,
                                     input logic [WB_PORTS*PREG_W-1:0] tags);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < WB_PORTS; k++) begin
            if (v[k] && (tags[k*PREG_W +: PREG_W] == tag)) begin
                hit = 1'b1;
            end
        end
        return hit && (tag != '0);
    endfunction

    assign IS_ready = (count_q < CNT_W'(IQ_LEN));
    assign insert   = DC_valid && IS_ready && !mispredict;
    assign issue    = iss_valid;
    assign iq_count = count_q;

    // An operand is ready at insert if not busy, is x0, or is being woken this cycle.
    assign ins_rdy1 = !rs1_busy || (DC_out_P_rs1 == '0) || tag_hit(DC_out_P_rs1, wb_valid, wb_tag);
    assign ins_rdy2 = !rs2_busy || (DC_out_P_rs2 == '0) || tag_hit(DC_out_P_rs2, wb_valid, wb_tag);

    // Gather the incoming payload into the stored layout.
    always_comb begin
        ins_pl         = '0;
        ins_pl.pc      = DC_out_pc;
        ins_pl.imm     = DC_out_imm;
        ins_pl.op      = DC_out_op;
        ins_pl.f3      = DC_out_f3;
        ins_pl.f7      = DC_out_f7;
        ins_pl.p_rs1   = DC_out_P_rs1;
        ins_pl.p_rs2   = DC_out_P_rs2;
        ins_pl.p_rd    = DC_out_P_rd;
        ins_pl.fu_sel  = DC_out_fu_sel;
        ins_pl.rob_idx = DC_out_rob_idx;
        ins_pl.jump    = DC_out_jump;
    end

    // Lowest-numbered free slot receives the next insert.
    always_comb begin
        logic found;
        found    = 1'b0;
        free_idx = '0;
        for (int i = 0; i < IQ_LEN; i++) begin
            if (!q[i].valid && !found) begin
                found    = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    // A slot requests issue when both operands are ready and its unit accepts.
    always_comb begin
        for (int i = 0; i < IQ_LEN; i++) begin
            req[i]     = q[i].valid && q[i].rdy1 && q[i].rdy2 && fu_ready[q[i].pl.fu_sel];
            rob_vec[i] = q[i].pl.rob_idx;
        end
    end

    iq_age_select #(
        .N (IQ_LEN)
    ) u_age_select (
        .req      (req),
        .rob_idx  (rob_vec),
        .rob_head (rob_head),
        .grant    (grant),
        .valid    (iss_valid)
    );

    // One-hot grant steers the winning payload to the issue port.
    always_comb begin
        sel_pl = '0;
        for (int i = 0; i < IQ_LEN; i++) begin
            if (grant[i]) begin
                sel_pl = q[i].pl;
            end
        end
    end

    assign iss_pc      = sel_pl.pc;
    assign iss_imm     = sel_pl.imm;
    assign iss_op      = sel_pl.op;
    assign iss_f3      = sel_pl.f3;
    assign iss_f7      = sel_pl.f7;
    assign iss_P_rs1   = sel_pl.p_rs1;
    assign iss_P_rs2   = sel_pl.p_rs2;
    assign iss_P_rd    = sel_pl.p_rd;
    assign iss_fu_sel  = sel_pl.fu_sel;
    assign iss_rob_idx = sel_pl.rob_idx;
    assign iss_jump    = sel_pl.jump;

    // Slot update: flush, insert into the free slot, retire the winner, apply wakeups.
    // Only valid bits are reset; payload and ready bits are rewritten on insert.
    always_ff @(posedge clk) begin
        for (int i = 0; i < IQ_LEN; i++) begin
            if (rst || mispredict) begin
                q[i].valid <= 1'b0;
            end else if (insert && (free_idx == IDX_W'(i))) begin
                q[i].valid <= 1'b1;
                q[i].rdy1  <= ins_rdy1;
                q[i].rdy2  <= ins_rdy2;
                q[i].pl    <= ins_pl;
            end else begin
                if (issue && grant[i]) begin
                    q[i].valid <= 1'b0;
                end
                if (q[i].valid && tag_hit(q[i].pl.p_rs1, wb_valid, wb_tag)) begin
                    q[i].rdy1 <= 1'b1;
                end
                if (q[i].valid && tag_hit(q[i].pl.p_rs2, wb_valid, wb_tag)) begin
                    q[i].rdy2 <= 1'b1;
                end
            end
        end
    end

    // Occupancy follows insert minus issue; a flush empties the queue.
    always_ff @(posedge clk) begin
        if (rst || mispredict) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + CNT_W'(insert) - CNT_W'(issue);
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: directed sequences, a step table and a randomized
// run checked against an in-order list model of in-flight micro-ops.
module tb_issue_queue;
    import issue_queue_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         DC_valid;
    logic [31:0]  DC_out_imm;
    logic [4:0]   DC_out_op;
    logic [2:0]   DC_out_f3;
    logic [6:0]   DC_out_f7;
    logic [6:0]   DC_out_P_rs1;
    logic [6:0]   DC_out_P_rs2;
    logic [6:0]   DC_out_P_rd;
    logic [2:0]   DC_out_fu_sel;
    logic [3:0]   DC_out_rob_idx;
    logic         DC_out_jump;
    logic [31:0]  DC_out_pc;
    logic         rs1_busy;
    logic         rs2_busy;
    logic         IS_ready;
    logic [1:0]   wb_valid;
    logic [13:0]  wb_tag;
    logic [3:0]   rob_head;
    logic [7:0]   fu_ready;
    logic         iss_valid;
    logic [31:0]  iss_pc;
    logic [31:0]  iss_imm;
    logic [4:0]   iss_op;
    logic [2:0]   iss_f3;
    logic [6:0]   iss_f7;
    logic [6:0]   iss_P_rs1;
    logic [6:0]   iss_P_rs2;
    logic [6:0]   iss_P_rd;
    logic [2:0]   iss_fu_sel;
    logic [3:0]   iss_rob_idx;
    logic         iss_jump;
    logic         mispredict;
    logic [3:0]   iq_count;

    issue_queue dut (
        .clk(clk), .rst(rst), .DC_valid(DC_valid),
        .DC_out_imm(DC_out_imm), .DC_out_op(DC_out_op), .DC_out_f3(DC_out_f3),
        .DC_out_f7(DC_out_f7), .DC_out_P_rs1(DC_out_P_rs1), .DC_out_P_rs2(DC_out_P_rs2),
        .DC_out_P_rd(DC_out_P_rd), .DC_out_fu_sel(DC_out_fu_sel),
        .DC_out_rob_idx(DC_out_rob_idx), .DC_out_jump(DC_out_jump), .DC_out_pc(DC_out_pc),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .IS_ready(IS_ready),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .rob_head(rob_head), .fu_ready(fu_ready),
        .iss_valid(iss_valid), .iss_pc(iss_pc), .iss_imm(iss_imm), .iss_op(iss_op),
        .iss_f3(iss_f3), .iss_f7(iss_f7), .iss_P_rs1(iss_P_rs1), .iss_P_rs2(iss_P_rs2),
        .iss_P_rd(iss_P_rd), .iss_fu_sel(iss_fu_sel), .iss_rob_idx(iss_rob_idx),
        .iss_jump(iss_jump), .mispredict(mispredict), .iq_count(iq_count)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    int n_chk = 0;
    int n_err = 0;

    // Expected issue signatures, oldest first.
    logic [107:0] exp_q[$];

    // One table step: inputs applied for a cycle and the outputs expected in it.
    typedef struct {
        logic       dcv;
        logic [3:0] rob;
        logic [6:0] rs1;
        logic       b1;
        logic [6:0] rs2;
        logic       b2;
        logic [2:0] fu;
        logic [1:0] wbv;
        logic [6:0] wt0;
        logic [6:0] wt1;
        logic [3:0] head;
        logic [7:0] fur;
        logic       e_iv;
        logic [3:0] e_rob;
        logic [3:0] e_cnt;
        logic       e_rdy;
    } vec_t;

    // Model of one in-flight micro-op, in allocation order.
    typedef struct {
        logic [107:0] sig;
        logic [3:0]   rob;
        logic [2:0]   fu;
        logic         need1;
        logic         need2;
        logic [6:0]   t1;
        logic [6:0]   t2;
        int           seq;
    } mop_t;

    mop_t m_q[$];
    int   seq = 0;
    vec_t tbl[24];

    function automatic vec_t mk(logic dcv, logic [3:0] rob, logic [6:0] rs1, logic b1,
                                logic [6:0] rs2, logic b2, logic [2:0] fu, logic [1:0] wbv,
                                logic [6:0] wt0, logic [6:0] wt1, logic [3:0] head,
                                logic [7:0] fur, logic e_iv, logic [3:0] e_rob,
                                logic [3:0] e_cnt, logic e_rdy);
        vec_t v;
        v.dcv = dcv; v.rob = rob; v.rs1 = rs1; v.b1 = b1; v.rs2 = rs2; v.b2 = b2;
        v.fu = fu; v.wbv = wbv; v.wt0 = wt0; v.wt1 = wt1; v.head = head; v.fur = fur;
        v.e_iv = e_iv; v.e_rob = e_rob; v.e_cnt = e_cnt; v.e_rdy = e_rdy;
        return v;
    endfunction

    function automatic logic [107:0] mk_sig(logic [31:0] pc, logic [31:0] imm, logic [4:0] op,
                                            logic [2:0] f3, logic [6:0] f7, logic [6:0] rs1,
                                            logic [6:0] rs2, logic [6:0] rd, logic [2:0] fu,
                                            logic [3:0] rob, logic jump);
        return {pc, imm, op, f3, f7, rs1, rs2, rd, fu, rob, jump};
    endfunction

    function automatic logic [107:0] dut_sig();
        return mk_sig(iss_pc, iss_imm, iss_op, iss_f3, iss_f7, iss_P_rs1, iss_P_rs2,
                      iss_P_rd, iss_fu_sel, iss_rob_idx, iss_jump);
    endfunction

    function automatic logic wb_hit(logic [6:0] t);
        return (wb_valid[0] && (wb_tag[6:0] == t)) || (wb_valid[1] && (wb_tag[13:7] == t));
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Driver tasks
    task automatic set_idle();
        rst        = 1'b0;
        DC_valid   = 1'b0;
        rs1_busy   = 1'b0;
        rs2_busy   = 1'b0;
        wb_valid   = 2'b00;
        wb_tag     = '0;
        mispredict = 1'b0;
    endtask

    task automatic drive_op(input logic [3:0] rob, input logic [6:0] rs1, input logic b1,
                            input logic [6:0] rs2, input logic b2, input logic [2:0] fu);
        DC_valid       = 1'b1;
        DC_out_rob_idx = rob;
        DC_out_P_rs1   = rs1;
        rs1_busy       = b1;
        DC_out_P_rs2   = rs2;
        rs2_busy       = b2;
        DC_out_fu_sel  = fu;
        DC_out_P_rd    = 7'(rob + 4'd1);
        DC_out_op      = OP_R_TYPE;
        DC_out_f3      = 3'd0;
        DC_out_f7      = 7'd0;
        DC_out_imm     = 32'h0;
        DC_out_jump    = 1'b0;
        DC_out_pc      = 32'h8000_0000 + {26'd0, rob, 2'b00};
    endtask

    // Compare the visible state 1 time unit after the inputs were applied.
    task automatic expect_state(input string nm, input logic e_iv, input logic [3:0] e_rob,
                                input logic [3:0] e_cnt, input logic e_rdy);
        #1;
        chk({nm, "_iss_valid"}, iss_valid, e_iv);
        if (e_iv) chk({nm, "_iss_rob_idx"}, iss_rob_idx, e_rob);
        chk({nm, "_iq_count"}, iq_count, e_cnt);
        chk({nm, "_IS_ready"}, IS_ready, e_rdy);
    endtask

    task automatic run_table();
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            set_idle();
            if (tbl[i].dcv) drive_op(tbl[i].rob, tbl[i].rs1, tbl[i].b1, tbl[i].rs2, tbl[i].b2, tbl[i].fu);
            wb_valid = tbl[i].wbv;
            wb_tag   = {tbl[i].wt1, tbl[i].wt0};
            rob_head = tbl[i].head;
            fu_ready = tbl[i].fur;
            expect_state($sformatf("vec%0d", i), tbl[i].e_iv, tbl[i].e_rob, tbl[i].e_cnt, tbl[i].e_rdy);
        end
    endtask

    task automatic run_random(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            logic can_ins;
            logic ins;
            int   k;
            mop_t m;
            @(negedge clk);
            set_idle();
            can_ins    = (m_q.size() < 8) && ((m_q.size() == 0) || ((seq - m_q[0].seq) < 15));
            rob_head   = (m_q.size() != 0) ? m_q[0].rob : 4'(seq);
            fu_ready   = 8'($urandom | $urandom);
            wb_valid   = 2'($urandom_range(0, 3));
            wb_tag     = {7'($urandom_range(1, 15)), 7'($urandom_range(1, 15))};
            mispredict = ($urandom_range(0, 49) == 0);
            DC_valid   = can_ins && ($urandom_range(0, 3) != 0);
            DC_out_pc      = $urandom;
            DC_out_imm     = $urandom;
            DC_out_op      = 5'($urandom_range(0, 31));
            DC_out_f3      = 3'($urandom_range(0, 7));
            DC_out_f7      = 7'($urandom_range(0, 127));
            DC_out_P_rs1   = 7'($urandom_range(0, 15));
            DC_out_P_rs2   = 7'($urandom_range(0, 15));
            DC_out_P_rd    = 7'($urandom_range(0, 127));
            DC_out_fu_sel  = 3'($urandom_range(0, 7));
            DC_out_rob_idx = 4'(seq);
            DC_out_jump    = 1'($urandom_range(0, 1));
            rs1_busy       = 1'($urandom_range(0, 1));
            rs2_busy       = 1'($urandom_range(0, 1));

            // Oldest micro-op with both operands available and its unit free.
            k = -1;
            for (int i = 0; i < m_q.size(); i++) begin
                if (k < 0 && !m_q[i].need1 && !m_q[i].need2 && fu_ready[m_q[i].fu]) k = i;
            end
            if (k >= 0) exp_q.push_back(m_q[k].sig);

            #1;
            chk("rnd_iss_valid", iss_valid, (k >= 0));
            if (iss_valid) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL rnd_extra_issue: got issue of rob %0d expected none", iss_rob_idx);
                end else begin
                    chk("rnd_payload", dut_sig(), exp_q.pop_front());
                end
            end else if (k >= 0) begin
                void'(exp_q.pop_back());
            end
            chk("rnd_iq_count", iq_count, m_q.size());
            chk("rnd_IS_ready", IS_ready, (m_q.size() < 8));

            // Advance the model across the coming edge.
            ins = DC_valid && !mispredict;
            if (mispredict) begin
                m_q.delete();
            end else begin
                if (k >= 0) m_q.delete(k);
                for (int i = 0; i < m_q.size(); i++) begin
                    if (m_q[i].need1 && wb_hit(m_q[i].t1)) m_q[i].need1 = 1'b0;
                    if (m_q[i].need2 && wb_hit(m_q[i].t2)) m_q[i].need2 = 1'b0;
                end
                if (ins) begin
                    m.sig   = mk_sig(DC_out_pc, DC_out_imm, DC_out_op, DC_out_f3, DC_out_f7,
                                     DC_out_P_rs1, DC_out_P_rs2, DC_out_P_rd, DC_out_fu_sel,
                                     DC_out_rob_idx, DC_out_jump);
                    m.rob   = DC_out_rob_idx;
                    m.fu    = DC_out_fu_sel;
                    m.t1    = DC_out_P_rs1;
                    m.t2    = DC_out_P_rs2;
                    m.need1 = rs1_busy && (DC_out_P_rs1 != 0) && !wb_hit(DC_out_P_rs1);
                    m.need2 = rs2_busy && (DC_out_P_rs2 != 0) && !wb_hit(DC_out_P_rs2);
                    m.seq   = seq;
                    m_q.push_back(m);
                end
            end
            if (ins) seq++;
        end
    endtask

    initial begin
        // Step table: scrambled wrap-around ages, blocked MUL, same-cycle and
        // port-1 wakeups, insert with issue, ignored invalid broadcast, tag 0.
        tbl[0]  = mk(1,  0,  5,0,  6,0, 0, 2'b00,  0, 0, 14, 8'h00, 0,  0,0,1);
        tbl[1]  = mk(1,  1,  5,0,  6,0, 0, 2'b00,  0, 0, 14, 8'h00, 0,  0,1,1);
        tbl[2]  = mk(1, 15,  5,0,  6,0, 0, 2'b00,  0, 0, 14, 8'h00, 0,  0,2,1);
        tbl[3]  = mk(1, 14,  5,0,  6,0, 0, 2'b00,  0, 0, 14, 8'h00, 0,  0,3,1);
        tbl[4]  = mk(0,  0,  0,0,  0,0, 0, 2'b00,  0, 0, 14, 8'hFF, 1, 14,4,1);
        tbl[5]  = mk(0,  0,  0,0,  0,0, 0, 2'b00,  0, 0, 14, 8'hFF, 1, 15,3,1);
        tbl[6]  = mk(0,  0,  0,0,  0,0, 0, 2'b00,  0, 0, 14, 8'hFF, 1,  0,2,1);
        tbl[7]  = mk(0,  0,  0,0,  0,0, 0, 2'b00,  0, 0, 14, 8'hFF, 1,  1,1,1);
        tbl[8]  = mk(0,  0,  0,0,  0,0, 0, 2'b00,  0, 0, 14, 8'hFF, 0,  0,0,1);
        tbl[9]  = mk(1,  2,  5,0,  6,0, 1, 2'b00,  0, 0,  2, 8'hFD, 0,  0,0,1);
        tbl[10] = mk(1,  3,  5,0,  6,0, 0, 2'b00,  0, 0,  2, 8'hFD, 0,  0,1,1);
        tbl[11] = mk(0,  0,  0,0,  0,0, 0, 2'b00,  0, 0,  2, 8'hFD, 1,  3,2,1);
        tbl[12] = mk(0,  0,  0,0,  0,0, 0, 2'b00,  0, 0,  2, 8'hFD, 0,  0,1,1);
        tbl[13] = mk(0,  0,  0,0,  0,0, 0, 2'b00,  0, 0,  2, 8'hFF, 1,  2,1,1);
        tbl[14] = mk(0,  0,  0,0,  0,0, 0, 2'b00,  0, 0,  2, 8'hFF, 0,  0,0,1);
        tbl[15] = mk(1,  4, 20,1,  0,0, 0, 2'b01, 20, 0,  4, 8'hFF, 0,  0,0,1);
        tbl[16] = mk(1,  5,  0,0, 33,1, 0, 2'b10,  0,33,  4, 8'hFF, 1,  4,1,1);
        tbl[17] = mk(0,  0,  0,0,  0,0, 0, 2'b00,  0, 0,  4, 8'hFF, 1,  5,1,1);
        tbl[18] = mk(1,  6, 40,1,  0,0, 0, 2'b01, 41,40,  4, 8'hFF, 0,  0,0,1);
        tbl[19] = mk(0,  0,  0,0,  0,0, 0, 2'b10,  0,40,  4, 8'hFF, 0,  0,1,1);
        tbl[20] = mk(0,  0,  0,0,  0,0, 0, 2'b00,  0, 0,  4, 8'hFF, 1,  6,1,1);
        tbl[21] = mk(1,  7,  0,1,  0,1, 0, 2'b00,  0, 0,  4, 8'hFF, 0,  0,0,1);
        tbl[22] = mk(0,  0,  0,0,  0,0, 0, 2'b00,  0, 0,  4, 8'hFF, 1,  7,1,1);
        tbl[23] = mk(0,  0,  0,0,  0,0, 0, 2'b00,  0, 0,  4, 8'hFF, 0,  0,0,1);

        // Reset
        set_idle();
        drive_op(0, 0, 0, 0, 0, 0);
        DC_valid = 1'b0;
        rob_head = 4'd0;
        fu_ready = 8'hFF;
        rst      = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        expect_state("reset", 0, 0, 0, 1);

        // Fill all eight slots with units blocked; queue reports full.
        fu_ready = 8'h00;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            set_idle();
            drive_op(4'(i), 0, 0, 0, 0, 0);
            expect_state($sformatf("fill%0d", i), 0, 0, 4'(i), 1);
        end
        @(negedge clk);
        set_idle();
        expect_state("full", 0, 0, 8, 0);
        @(negedge clk);
        mispredict = 1'b1;
        expect_state("full_flush", 0, 0, 8, 0);
        @(negedge clk);
        set_idle();
        expect_state("after_full_flush", 0, 0, 0, 1);

        // Busy rs1 woken by a broadcast two cycles after insert.
        fu_ready = 8'hFF;
        rob_head = 4'd3;
        @(negedge clk);
        drive_op(3, 12, 1, 0, 0, FU_ALU);
        expect_state("wake_ins", 0, 0, 0, 1);
        @(negedge clk);
        set_idle();
        expect_state("wake_wait", 0, 0, 1, 1);
        @(negedge clk);
        wb_valid = 2'b01;
        wb_tag   = {7'd0, 7'd12};
        expect_state("wake_pulse", 0, 0, 1, 1);
        @(negedge clk);
        set_idle();
        expect_state("wake_issue", 1, 3, 1, 1);
        @(negedge clk);
        expect_state("wake_done", 0, 0, 0, 1);

        // Mispredict together with a dispatch: queue empties, dispatch dropped.
        fu_ready = 8'h00;
        rob_head = 4'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            set_idle();
            drive_op(4'(i), 0, 0, 0, 0, 0);
            expect_state($sformatf("mp_fill%0d", i), 0, 0, 4'(i), 1);
        end
        @(negedge clk);
        set_idle();
        drive_op(9, 0, 0, 0, 0, 0);
        mispredict = 1'b1;
        expect_state("mp_cycle", 0, 0, 5, 1);
        @(negedge clk);
        set_idle();
        fu_ready = 8'hFF;
        expect_state("mp_after", 0, 0, 0, 1);

        // Reset in the middle of operation, with wakeups on the bus.
        fu_ready = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_idle();
            drive_op(4'(i), 9, 1, 0, 0, 0);
            expect_state($sformatf("rst_fill%0d", i), 0, 0, 4'(i), 1);
        end
        @(negedge clk);
        set_idle();
        rst      = 1'b1;
        wb_valid = 2'b11;
        wb_tag   = {7'd9, 7'd9};
        expect_state("rst_mid", 0, 0, 3, 1);
        @(negedge clk);
        set_idle();
        fu_ready = 8'hFF;
        expect_state("rst_after", 0, 0, 0, 1);

        run_table();
        run_random(2000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
